// File: rtl/vertex_streamer.sv
// vertex_streamer: queues 4-word vertices from the matrix multiplier and
// serialises them as an AXI-stream, one component word per beat, with tlast
// marking the w component of each vertex.
module vertex_streamer #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 32
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           valid_in,
   input  logic [3:0][WORD_W-1:0]         vec_in,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [WORD_W-1:0]              m_axis_tdata,
   output logic                           m_axis_tlast,
   output logic [$clog2(DEPTH+1)-1:0]     count_out,
   output logic                           overflow_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state_reg, state_next;
   logic [1:0]             idx_reg, idx_next;
   logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]       count_reg, count_next;
   logic                   overflow_reg;
   logic [3:0][WORD_W-1:0] mem [DEPTH];

   logic full, handshake, pop, push, drop;

   // A pop frees a slot in the same cycle, so a push at full is still accepted
   // when the last word of the head vector is being taken.
   assign full       = (count_reg == CNT_W'(DEPTH));
   assign handshake  = m_axis_tvalid & m_axis_tready;
   assign pop        = handshake & (idx_reg == 2'd3);
   assign push       = valid_in & (~full | pop);
   assign drop       = valid_in & full & ~pop;
   assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

   assign m_axis_tdata = mem[rd_ptr_reg][idx_reg];
   assign m_axis_tlast = (idx_reg == 2'd3);
   assign count_out    = count_reg;
   assign overflow_out = overflow_reg;

   // Vector storage; pointers are PTR_W bits wide so they wrap modulo DEPTH.
   always_ff @(posedge clk_in) begin
      if (push && !rst_in) begin
         mem[wr_ptr_reg] <= vec_in;
      end
   end

   // Queue bookkeeping and FSM state register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg    <= IDLE;
         idx_reg      <= 2'd0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         count_reg  <= count_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Next-state and output logic: IDLE waits one cycle on a nonzero count,
   // SEND walks the component index and leaves only when the queue drains.
   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      m_axis_tvalid = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               state_next = SEND;
               idx_next   = 2'd0;
            end
         end
         SEND: begin
            m_axis_tvalid = 1'b1;
            if (handshake) begin
               idx_next = idx_reg + 2'd1;
            end
            if (pop && (count_next == '0)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = 2'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_vertex_streamer.sv
// Testbench for vertex_streamer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-level reference model.
module tb_vertex_streamer;

   localparam int DEPTH  = 4;
   localparam int WORD_W = 32;

   typedef logic [3:0][WORD_W-1:0] vec_t;

   typedef struct {
      bit          valid;
      vec_t        vec;
      bit          rdy;
      bit          e_tv;
      logic [31:0] e_data;
      bit          e_last;
      int          e_cnt;
   } row_t;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b1;
   logic              valid_in = 1'b0;
   vec_t              vec_in = '0;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b0;
   logic [WORD_W-1:0] m_axis_tdata;
   logic              m_axis_tlast;
   logic [2:0]        count_out;
   logic              overflow_out;

   int checks   = 0;
   int failures = 0;

   vertex_streamer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .valid_in      (valid_in),
      .vec_in        (vec_in),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .count_out     (count_out),
      .overflow_out  (overflow_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic vec_t mkv(input int a, input int b, input int c, input int d);
      vec_t v;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      return v;
   endfunction

   function automatic row_t mkr(input bit v, input vec_t d, input bit r, input bit tv,
                                input int data, input bit last, input int cnt);
      row_t x;
      x.valid = v; x.vec = d; x.rdy = r; x.e_tv = tv;
      x.e_data = data; x.e_last = last; x.e_cnt = cnt;
      return x;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs depend on state only, so they
   // can be compared right after driving.
   task automatic drive(input bit v, input vec_t d, input bit r, input bit rs);
      @(negedge clk_in);
      valid_in      = v;
      vec_in        = d;
      m_axis_tready = r;
      rst_in        = rs;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, 1'b1);
   endtask

   row_t tbl[$];
   vec_t z;

   // reference model state
   vec_t mq[$];
   int   m_idx;
   bit   m_send;
   bit   m_ovf;

   initial begin
      int nw, nl;
      int words[$];
      z = '0;

      // ---------------- table: single vector, backpressure, back-to-back
      tbl.push_back(mkr(1, mkv(1,2,3,4), 1, 0, 0, 0, 0));
      tbl.push_back(mkr(0, z, 1, 0, 0, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 1, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 2, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 3, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 4, 1, 1));
      tbl.push_back(mkr(0, z, 1, 0, 0, 0, 0));
      tbl.push_back(mkr(1, mkv(1,2,3,4), 1, 0, 0, 0, 0));
      tbl.push_back(mkr(0, z, 1, 0, 0, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 1, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 2, 0, 1));
      tbl.push_back(mkr(0, z, 0, 1, 3, 0, 1));
      tbl.push_back(mkr(0, z, 0, 1, 3, 0, 1));
      tbl.push_back(mkr(0, z, 0, 1, 3, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 3, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 4, 1, 1));
      tbl.push_back(mkr(0, z, 1, 0, 0, 0, 0));
      tbl.push_back(mkr(1, mkv(5,6,7,8), 1, 0, 0, 0, 0));
      tbl.push_back(mkr(1, mkv(11,12,13,14), 1, 0, 0, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 5, 0, 2));
      tbl.push_back(mkr(0, z, 1, 1, 6, 0, 2));
      tbl.push_back(mkr(0, z, 1, 1, 7, 0, 2));
      tbl.push_back(mkr(0, z, 1, 1, 8, 1, 2));
      tbl.push_back(mkr(0, z, 1, 1, 11, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 12, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 13, 0, 1));
      tbl.push_back(mkr(0, z, 1, 1, 14, 1, 1));
      tbl.push_back(mkr(0, z, 1, 0, 0, 0, 0));

      do_reset();
      do_reset();
      drive(1'b0, z, 1'b0, 1'b0);
      chk("reset_tvalid", m_axis_tvalid, 0);
      chk("reset_count", count_out, 0);
      chk("reset_overflow", overflow_out, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].valid, tbl[i].vec, tbl[i].rdy, 1'b0);
         chk($sformatf("tbl%0d_tvalid", i), m_axis_tvalid, tbl[i].e_tv);
         chk($sformatf("tbl%0d_count", i), count_out, tbl[i].e_cnt);
         chk($sformatf("tbl%0d_overflow", i), overflow_out, 0);
         if (tbl[i].e_tv) begin
            chk($sformatf("tbl%0d_tdata", i), m_axis_tdata, tbl[i].e_data);
            chk($sformatf("tbl%0d_tlast", i), m_axis_tlast, tbl[i].e_last);
         end
         $display("table row %0d: tvalid=%0d tdata=%0d tlast=%0d count=%0d",
                  i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, count_out);
      end

      // ---------------- overflow: five pushes into a 4-deep queue
      do_reset();
      for (int k = 1; k <= 5; k++)
         drive(1'b1, mkv(10*k, 10*k+1, 10*k+2, 10*k+3), 1'b0, 1'b0);
      drive(1'b0, z, 1'b0, 1'b0);
      drive(1'b0, z, 1'b0, 1'b0);
      chk("ovf_count", count_out, 4);
      chk("ovf_flag", overflow_out, 1);
      nw = 0; nl = 0;
      for (int c = 0; c < 40; c++) begin
         drive(1'b0, z, 1'b1, 1'b0);
         if (m_axis_tvalid) begin
            chk($sformatf("ovf_word%0d", nw), m_axis_tdata, 10 + 10*(nw/4) + nw%4);
            if (m_axis_tlast) nl++;
            nw++;
         end
      end
      chk("ovf_nwords", nw, 16);
      chk("ovf_ntlast", nl, 4);
      chk("ovf_sticky", overflow_out, 1);
      $display("overflow sequence: words=%0d tlast=%0d", nw, nl);

      // ---------------- full queue with push in the tlast handshake cycle
      do_reset();
      for (int k = 1; k <= 4; k++)
         drive(1'b1, mkv(10*k, 10*k+1, 10*k+2, 10*k+3), 1'b0, 1'b0);
      drive(1'b0, z, 1'b1, 1'b0);
      chk("fp_tvalid", m_axis_tvalid, 1);
      chk("fp_first", m_axis_tdata, 10);
      chk("fp_count_full", count_out, 4);
      drive(1'b0, z, 1'b1, 1'b0);
      drive(1'b0, z, 1'b1, 1'b0);
      drive(1'b1, mkv(7,7,7,7), 1'b1, 1'b0);
      chk("fp_tlast", m_axis_tlast, 1);
      chk("fp_tdata13", m_axis_tdata, 13);
      drive(1'b0, z, 1'b0, 1'b0);
      chk("fp_count_after", count_out, 4);
      chk("fp_overflow", overflow_out, 0);
      chk("fp_next_head", m_axis_tdata, 20);
      words.delete();
      for (int c = 0; c < 40; c++) begin
         drive(1'b0, z, 1'b1, 1'b0);
         if (m_axis_tvalid) words.push_back(int'(m_axis_tdata));
      end
      chk("fp_nwords", words.size(), 16);
      if (words.size() == 16) begin
         chk("fp_w12", words[12], 7);
         chk("fp_w15", words[15], 7);
         chk("fp_w11", words[11], 43);
      end
      $display("full-plus-pop sequence: drained %0d words", words.size());

      // ---------------- reset in the middle of a vector
      do_reset();
      drive(1'b1, mkv(1,2,3,4), 1'b1, 1'b0);
      drive(1'b0, z, 1'b1, 1'b0);
      chk("rm_idle", m_axis_tvalid, 0);
      drive(1'b0, z, 1'b1, 1'b0);
      chk("rm_w1", m_axis_tdata, 1);
      drive(1'b0, z, 1'b1, 1'b0);
      chk("rm_w2", m_axis_tdata, 2);
      drive(1'b0, z, 1'b1, 1'b1);
      drive(1'b0, z, 1'b1, 1'b0);
      chk("rm_tvalid", m_axis_tvalid, 0);
      chk("rm_count", count_out, 0);
      drive(1'b1, mkv(9,8,7,6), 1'b1, 1'b0);
      drive(1'b0, z, 1'b1, 1'b0);
      drive(1'b0, z, 1'b1, 1'b0);
      chk("rm_new_tvalid", m_axis_tvalid, 1);
      chk("rm_new_first", m_axis_tdata, 9);
      chk("rm_new_tlast", m_axis_tlast, 0);
      $display("reset mid-vector: restart word=%0d", m_axis_tdata);

      // ---------------- randomized run against the queue model
      do_reset();
      mq.delete(); m_idx = 0; m_send = 0; m_ovf = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit rs, v, r, hs, pp;
         int old, rdy_pct;
         vec_t d;
         rdy_pct = ((cyc / 200) % 2 == 0) ? 85 : 20;
         rs = ($urandom_range(0, 249) == 0);
         v  = ($urandom_range(0, 99) < 45);
         r  = ($urandom_range(0, 99) < rdy_pct);
         for (int j = 0; j < 4; j++) d[j] = $urandom;
         drive(v, d, r, rs);
         chk("rnd_tvalid", m_axis_tvalid, m_send);
         chk("rnd_count", count_out, mq.size());
         chk("rnd_overflow", overflow_out, m_ovf);
         if (m_send) begin
            chk("rnd_tdata", m_axis_tdata, mq[0][m_idx]);
            chk("rnd_tlast", m_axis_tlast, (m_idx == 3));
         end
         if (cyc % 500 == 0)
            $display("random cycle %0d: model queue=%0d dut count=%0d", cyc, mq.size(), count_out);
         if (rs) begin
            mq.delete(); m_idx = 0; m_send = 0; m_ovf = 0;
         end else begin
            hs  = m_send && r;
            pp  = hs && (m_idx == 3);
            old = mq.size();
            if (pp) void'(mq.pop_front());
            if (v) begin
               if (old < DEPTH || pp) mq.push_back(d);
               else m_ovf = 1;
            end
            if (hs) m_idx = (m_idx + 1) % 4;
            if (!m_send) begin
               if (old != 0) begin
                  m_send = 1;
                  m_idx  = 0;
               end
            end else if (pp && mq.size() == 0) begin
               m_send = 0;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
